// File: rtl/zc_pkg.sv
// Shared types and helpers for the zero-crossing period meter.
package zc_pkg;

    localparam int unsigned CW_DEF = 32;
    localparam int unsigned SAT_W  = 64;
    localparam int unsigned SAT_W1 = SAT_W + 1;

    typedef enum logic [0:0] {
        SEEK  = 1'b0,
        COUNT = 1'b1
    } zc_state_e;

    // Unsigned add clamped to 2^w-1; w must not exceed SAT_W
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      w
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (SAT_W1'(1) << w) - SAT_W1'(1);
        if (sum > lim) begin
            return lim[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/zc_period_meter_if.sv
// Sample input and period result bus of the zero-crossing period meter.
// Amplitude results exist only when ZC_PEAK_DETECT_EN is defined.
interface zc_period_meter_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 32
);
    logic                 en;
    logic signed [DW-1:0] din;
    logic [CW-1:0]        period_sum;
    logic [CW-1:0]        period_avg;
    logic                 period_valid;
    logic                 locked;
    logic                 timeout;
`ifdef ZC_PEAK_DETECT_EN
    logic signed [DW-1:0] amp_max;
    logic signed [DW-1:0] amp_min;

    modport master (
        output en, din,
        input  period_sum, period_avg, period_valid, locked, timeout, amp_max, amp_min
    );
    modport slave (
        input  en, din,
        output period_sum, period_avg, period_valid, locked, timeout, amp_max, amp_min
    );
`else
    modport master (
        output en, din,
        input  period_sum, period_avg, period_valid, locked, timeout
    );
    modport slave (
        input  en, din,
        output period_sum, period_avg, period_valid, locked, timeout
    );
`endif
endinterface

// File: rtl/zc_hyst_detect.sv
// Rising zero-crossing detector with symmetric hysteresis.
module zc_hyst_detect #(
    parameter int unsigned DW   = 16,
    parameter int unsigned HYST = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [DW-1:0] i_din,
    output logic                 o_event_c
);

    localparam logic signed [DW-1:0] POS_TH = DW'(HYST);
    localparam logic signed [DW-1:0] NEG_TH = -POS_TH;

    logic r_armed;
    logic w_low;
    logic w_rise;

    assign w_low     = (i_din < NEG_TH);
    assign w_rise    = r_armed && (i_din >= POS_TH);
    assign o_event_c = i_en && w_rise;

    // Arm below -HYST, disarm on the crossing strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (i_en) begin
            if (w_rise) begin
                r_armed <= 1'b0;
            end else if (w_low) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/zc_period_meter.sv
// Measures the period (in strobes) between rising zero crossings and
// averages it over 2^AVG_LOG2 periods. Optional ZC_PEAK_DETECT_EN adds
// per-window min/max amplitude results.
module zc_period_meter
    import zc_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned HYST     = 64,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    zc_period_meter_if.slave  bus
);

    localparam int unsigned   NP_W    = AVG_LOG2 + 1;
    localparam logic [NP_W-1:0] NP_FULL = NP_W'(1) << AVG_LOG2;

    zc_state_e       r_state;
    zc_state_e       w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_acc;
    logic [NP_W-1:0] r_np;
    logic [CW-1:0]   r_sum;
    logic [CW-1:0]   r_avg;
    logic            r_valid;
    logic            r_timeout;
    logic            r_locked;

    logic            w_event;
    logic            w_timeout_hit;
    logic            w_complete;
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_acc_add;
    logic [NP_W-1:0] w_np_inc;
    logic [CW-1:0]   w_cnt_next;
    logic [CW-1:0]   w_acc_next;
    logic [NP_W-1:0] w_np_next;
    logic [CW-1:0]   w_sum_next;
    logic [CW-1:0]   w_avg_next;
    logic            w_valid_next;
    logic            w_timeout_next;

    zc_hyst_detect #(
        .DW   (DW),
        .HYST (HYST)
    ) u_hyst (
        .clk       (clk),
        .rst       (rst),
        .i_en      (bus.en),
        .i_din     (bus.din),
        .o_event_c (w_event)
    );

    assign w_cnt_inc     = CW'(sat_add(SAT_W'(r_cnt), SAT_W'(1), CW));
    assign w_acc_add     = CW'(sat_add(SAT_W'(r_acc), SAT_W'(r_cnt), CW));
    assign w_np_inc      = r_np + NP_W'(1);
    assign w_complete    = (r_state == COUNT) && w_event && (w_np_inc == NP_FULL);
    // An event on the same strobe pre-empts the timeout
    assign w_timeout_hit = (r_state == COUNT) && bus.en && !w_event && (r_cnt >= CW'(TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: lock on first crossing, drop lock on timeout
    always_comb begin
        w_state_next = r_state;
        if (bus.en) begin
            case (r_state)
                SEEK:    if (w_event)       w_state_next = COUNT;
                COUNT:   if (w_timeout_hit) w_state_next = SEEK;
                default: w_state_next = SEEK;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        w_cnt_next     = r_cnt;
        w_acc_next     = r_acc;
        w_np_next      = r_np;
        w_sum_next     = r_sum;
        w_avg_next     = r_avg;
        w_valid_next   = 1'b0;
        w_timeout_next = r_timeout;
        if (bus.en) begin
            w_cnt_next = w_event ? CW'(1) : w_cnt_inc;
            case (r_state)
                SEEK: begin
                    if (w_event) begin
                        w_acc_next = '0;
                        w_np_next  = '0;
                    end
                end
                COUNT: begin
                    if (w_complete) begin
                        w_sum_next     = w_acc_add;
                        w_avg_next     = w_acc_add >> AVG_LOG2;
                        w_valid_next   = 1'b1;
                        w_timeout_next = 1'b0;
                        w_acc_next     = '0;
                        w_np_next      = '0;
                    end else if (w_event) begin
                        w_acc_next = w_acc_add;
                        w_np_next  = w_np_inc;
                    end else if (w_timeout_hit) begin
                        w_timeout_next = 1'b1;
                        w_acc_next     = '0;
                        w_np_next      = '0;
                    end
                end
                default: begin
                    w_acc_next = '0;
                    w_np_next  = '0;
                end
            endcase
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_np      <= '0;
            r_sum     <= '0;
            r_avg     <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_acc     <= w_acc_next;
            r_np      <= w_np_next;
            r_sum     <= w_sum_next;
            r_avg     <= w_avg_next;
            r_valid   <= w_valid_next;
            r_timeout <= w_timeout_next;
            r_locked  <= (w_state_next == COUNT);
        end
    end

    assign bus.period_sum   = r_sum;
    assign bus.period_avg   = r_avg;
    assign bus.period_valid = r_valid;
    assign bus.locked       = r_locked;
    assign bus.timeout      = r_timeout;

`ifdef ZC_PEAK_DETECT_EN
    logic signed [DW-1:0] r_max;
    logic signed [DW-1:0] r_min;
    logic signed [DW-1:0] r_amp_max;
    logic signed [DW-1:0] r_amp_min;
    logic                 r_trk_reload;
    logic signed [DW-1:0] w_max_cur;
    logic signed [DW-1:0] w_min_cur;
    logic                 w_win_start;

    assign w_win_start = (r_state == SEEK) && w_event;

    // Running extremes including the current sample
    always_comb begin
        w_max_cur = r_max;
        w_min_cur = r_min;
        if (r_trk_reload || (bus.din > r_max)) w_max_cur = bus.din;
        if (r_trk_reload || (bus.din < r_min)) w_min_cur = bus.din;
    end

    // Trackers restart on the sample after a window boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max        <= '0;
            r_min        <= '0;
            r_amp_max    <= '0;
            r_amp_min    <= '0;
            r_trk_reload <= 1'b1;
        end else if (bus.en) begin
            r_max        <= w_max_cur;
            r_min        <= w_min_cur;
            r_trk_reload <= w_win_start || w_complete;
            if (w_complete) begin
                r_amp_max <= w_max_cur;
                r_amp_min <= w_min_cur;
            end
        end
    end

    assign bus.amp_max = r_amp_max;
    assign bus.amp_min = r_amp_min;
`endif

endmodule

// File: tb/tb_zc_period_meter.sv
// Directed bench for zc_period_meter: vector table plus corner sequences.
module tb_zc_period_meter;

    localparam int HYST = 64;

    typedef struct {
        string name;
        int    kind;      // 0 = sine, 1 = square with alternating half-periods
        int    amp;
        int    pa;
        int    pb;
        int    div;       // strobe every div clocks
        int    exp_sum;
        int    exp_avg;
        int    exp_max;
        int    exp_min;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zc_period_meter_if #(.DW(16), .CW(32)) bus ();

    zc_period_meter #(
        .DW       (16),
        .CW       (32),
        .HYST     (64),
        .AVG_LOG2 (3),
        .TIMEOUT  (1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_pass  = 0;
    int     n_total = 0;
    int     m_armed;
    int     m_events;
    int     m_ev_at_valid;
    int     valid_seen;
    int     extra_valid;
    int     g_k;
    longint cap_sum;
    longint cap_avg;
    longint cap_locked;
    longint cap_to;
    int     cap_max;
    int     cap_min;
    vec_t   vecs[4];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else            n_pass++;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sum"},     longint'(bus.period_sum), 0);
        chk({tag, "_avg"},     longint'(bus.period_avg), 0);
        chk({tag, "_valid"},   longint'(bus.period_valid), 0);
        chk({tag, "_locked"},  longint'(bus.locked), 0);
        chk({tag, "_timeout"}, longint'(bus.timeout), 0);
    endtask

    function automatic int sample_at(input int kind, input int amp, input int pa,
                                     input int pb, input int k);
        int  pos;
        real ph;
        if (kind == 0) begin
            ph = 2.0 * 3.141592653589793 * real'(k) / real'(pa);
            return int'(real'(amp) * $sin(ph));
        end
        pos = k % (pa + pb);
        if (pos < pa) return (pos < pa / 2) ? -amp : amp;
        pos = pos - pa;
        return (pos < pb / 2) ? -amp : amp;
    endfunction

    task automatic model_clear();
        m_armed     = 0;
        m_events    = 0;
        valid_seen  = 0;
        extra_valid = 0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One strobe; the cycles between strobes must keep period_valid low
    task automatic strobe(input int val, input int div);
        @(negedge clk);
        bus.en  = 1'b1;
        bus.din = 16'(val);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        if (val < -HYST) m_armed = 1;
        else if (m_armed != 0 && val >= HYST) begin
            m_armed = 0;
            m_events++;
        end
        if (bus.period_valid) begin
            valid_seen    = 1;
            m_ev_at_valid = m_events;
            cap_sum       = longint'(bus.period_sum);
            cap_avg       = longint'(bus.period_avg);
            cap_locked    = longint'(bus.locked);
            cap_to        = longint'(bus.timeout);
`ifdef ZC_PEAK_DETECT_EN
            cap_max       = int'(bus.amp_max);
            cap_min       = int'(bus.amp_min);
`endif
        end
        for (int i = 1; i < div; i++) begin
            @(posedge clk);
            #1;
            if (bus.period_valid) extra_valid++;
        end
    endtask

    task automatic run_until_valid(input int kind, input int amp, input int pa,
                                   input int pb, input int div, input int budget);
        valid_seen  = 0;
        extra_valid = 0;
        for (int n = 0; n < budget && valid_seen == 0; n++) begin
            strobe(sample_at(kind, amp, pa, pb, g_k), div);
            g_k++;
        end
    endtask

    initial begin
        int noise;
        cap_max = 0;
        cap_min = 0;
        vecs[0] = '{"sine_en1",  0, 10000, 100, 100, 1, 800, 100, 10000, -10000};
        vecs[1] = '{"sine_en4",  0, 10000, 100, 100, 4, 800, 100, 10000, -10000};
        vecs[2] = '{"sq_alt1",   1, 5000,  100, 101, 1, 804, 100, 5000,  -5000};
        vecs[3] = '{"sq_alt3",   1, 5000,  100, 101, 3, 804, 100, 5000,  -5000};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            chk_outputs_zero({vecs[v].name, "_rst"});
            g_k = 0;
            run_until_valid(vecs[v].kind, vecs[v].amp, vecs[v].pa, vecs[v].pb,
                            vecs[v].div, 3000);
            chk({vecs[v].name, "_valid_seen"}, valid_seen, 1);
            chk({vecs[v].name, "_events"},     m_ev_at_valid, 9);
            chk({vecs[v].name, "_sum"},        cap_sum, vecs[v].exp_sum);
            chk({vecs[v].name, "_avg"},        cap_avg, vecs[v].exp_avg);
            chk({vecs[v].name, "_locked"},     cap_locked, 1);
            chk({vecs[v].name, "_timeout"},    cap_to, 0);
            chk({vecs[v].name, "_extra_valid"}, extra_valid, 0);
            @(posedge clk);
            #1;
            chk({vecs[v].name, "_valid_drop"}, longint'(bus.period_valid), 0);
`ifdef ZC_PEAK_DETECT_EN
            chk({vecs[v].name, "_amp_max"},
                longint'(cap_max >= vecs[v].exp_max - 1 && cap_max <= vecs[v].exp_max + 1), 1);
            chk({vecs[v].name, "_amp_min"},
                longint'(cap_min >= vecs[v].exp_min - 1 && cap_min <= vecs[v].exp_min + 1), 1);
`endif
        end

        // Timeout: noise inside the hysteresis band after lock
        do_reset();
        g_k = 0;
        run_until_valid(0, 10000, 100, 100, 1, 3000);
        chk("to_pre_sum", cap_sum, 800);
        for (int i = 0; i < 999; i++) begin
            noise = int'($urandom_range(100)) - 50;
            strobe(noise, 1);
        end
        chk("to_999_locked",  longint'(bus.locked), 1);
        chk("to_999_timeout", longint'(bus.timeout), 0);
        strobe(-50, 1);
        chk("to_1000_locked",  longint'(bus.locked), 0);
        chk("to_1000_timeout", longint'(bus.timeout), 1);
        chk("to_hold_sum",     longint'(bus.period_sum), 800);
        chk("to_hold_avg",     longint'(bus.period_avg), 100);
        repeat (5) @(posedge clk);
        #1;
        chk("to_frozen_locked", longint'(bus.locked), 0);
        model_clear();
        g_k = 0;
        run_until_valid(1, 5000, 100, 100, 1, 3000);
        chk("to_rec_seen",    valid_seen, 1);
        chk("to_rec_events",  m_ev_at_valid, 9);
        chk("to_rec_timeout", cap_to, 0);
        chk("to_rec_sum",     cap_sum, 800);
        chk("to_rec_locked",  cap_locked, 1);

        // Reset mid-window after five more periods
        m_events = 0;
        for (int n = 0; n < 2000 && m_events < 5; n++) begin
            strobe(sample_at(1, 5000, 100, 100, g_k), 1);
            g_k++;
        end
        for (int n = 0; n < 30; n++) begin
            strobe(sample_at(1, 5000, 100, 100, g_k), 1);
            g_k++;
        end
        chk("mid_pre_locked", longint'(bus.locked), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        g_k = 0;
        run_until_valid(1, 5000, 100, 100, 1, 3000);
        chk("mid_rec_seen",   valid_seen, 1);
        chk("mid_rec_events", m_ev_at_valid, 9);
        chk("mid_rec_sum",    cap_sum, 800);
        chk("mid_rec_avg",    cap_avg, 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/zc_period_meter.md
Name: zc_period_meter

Overview:
- Downstream consumer of the IIR filter stage.
- Takes the filtered signed sample stream on the same sample strobe and detects rising zero crossings with hysteresis.
- Measures the period in samples and averages it over 2^AVG_LOG2 periods.
- Reports the result to the PS-side register file for frequency readout of the separated tone.

Parameters:
- DW, 16, sample width (matches filter output dout)
- CW, 32, period counter / accumulator width
- HYST, 64, hysteresis threshold magnitude in LSBs (positive, < 2^(DW-1))
- AVG_LOG2, 3, log2 of the number of periods averaged
- TIMEOUT, 1000000, strobes without a rising crossing before lock is dropped

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-high reset
- en, input, 1, sample strobe, one clk wide; same strobe that drives the filter
- din, input, DW signed, filtered sample, valid when en=1
- period_sum, output, CW, sum of the last 2^AVG_LOG2 periods, in samples
- period_avg, output, CW, period_sum >> AVG_LOG2
- period_valid, output, 1, one-clk pulse when period_sum/period_avg update
- locked, output, 1, high while in COUNT state
- timeout, output, 1, sticky flag: set on timeout, cleared on next period_valid

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-high on rst.
  - On reset, all outputs are 0, state is SEEK, and all counters and the armed flag are 0.
- Sampling:
  - All logic advances only on clk edges where en=1, except the period_valid clear.
  - period_valid is high exactly one clk after the completing en and is low otherwise.
- Hysteresis:
  - armed is set when din < -HYST.
  - A rising event occurs on a strobe where armed=1 and din >= +HYST; armed is cleared on that strobe.
  - Values in [-HYST, +HYST) never create events.
- Period counting:
  - At a rising event, cnt is loaded with 1.
  - On every other strobe, cnt increments, saturating at 2^CW-1.
  - The period for an event is the cnt value at that event, i.e. the number of strobes since the previous event.
  - Example: events on strobe 0 and strobe 100 give a period of 100.
- State machine:
  - SEEK: waiting for the first rising event. On an event, go to COUNT with acc=0 and np=0, and load cnt.
  - COUNT: on an event, acc += cnt and np += 1.
    - When np reaches 2^AVG_LOG2: register period_sum=acc (including the current period), period_avg=acc>>AVG_LOG2, pulse period_valid, clear timeout, reset acc and np to 0, and stay in COUNT.
  - COUNT timeout: if cnt reaches TIMEOUT without an event, go to SEEK, set timeout=1, and discard acc. period_sum and period_avg hold their last values.
  - locked = (state==COUNT).
- Widths and overflow:
  - acc is CW bits and saturates at 2^CW-1.
  - The first valid result appears after 2^AVG_LOG2+1 rising events.
- Boundary conditions:
  - An event and a timeout on the same strobe: the event wins.
  - en held low: state frozen.
  - Reset asserted mid-measurement: immediate return to the reset state; partial acc is lost.
  - din exactly +HYST counts as an event; exactly -HYST does not arm.

Optional Feature:
- Macro: ZC_PEAK_DETECT_EN.
- With the macro defined:
  - Extra ports amp_max and amp_min (DW signed each).
  - Running max and min of din are tracked over the same averaging window.
  - Both are registered together with period_sum on period_valid, then the trackers reset to the next sample.
  - Reset value of amp_max and amp_min is 0.
- Without the macro: those ports and the tracking logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package zc_pkg holds:
  - state enum (SEEK, COUNT)
  - CW default
  - saturating-add helper function
- One natural sub-module: zc_hyst_detect, holding the armed flag and the rising-event output, registered on en.
- The counting FSM stays in the top level.

Test Plan:
- Sine, amplitude 10000, period 100 strobes, AVG_LOG2=3, en every clk -> first period_valid after the 9th rising crossing; period_sum=800, period_avg=100, locked=1.
- Same sine with en every 4th clk -> identical values; period_valid one clk after the completing en.
- Alternating periods 100/101, square wave ±5000 -> period_sum=804, period_avg=100.
- Random noise within ±50 with HYST=64 after lock, TIMEOUT=1000 -> timeout=1 and locked=0 after 1000 strobes; period_sum holds 800; next valid result clears timeout.
- rst pulsed mid-window after 5 periods -> all outputs 0 immediately; the next valid result needs a fresh 9 events.
- ZC_PEAK_DETECT_EN, sine ±10000 -> amp_max=10000 and amp_min=-10000 (±1 LSB quantisation) at period_valid.
